// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU: resolves operand forwarding, picks operand B,
// decodes ALUOp/funct into the ALU control code and holds the result behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [4:0]        in_rs_addr,
    input  logic [4:0]        in_rt_addr,
    input  logic              in_alu_src,
    input  logic [1:0]        in_alu_op,
    input  logic [5:0]        in_funct,
    input  logic              exm_reg_write,
    input  logic [4:0]        exm_rd,
    input  logic [DATA_W-1:0] exm_value,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_reg_1,
    output logic [DATA_W-1:0] alu_reg_2,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] store_data,
    output logic              illegal_op
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    // EX/MEM is the younger producer, so it shadows MEM/WB; $zero is never forwarded.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [4:0]        src_addr,
        input logic [DATA_W-1:0] rf_val,
        input logic              exm_we,
        input logic [4:0]        exm_dst,
        input logic [DATA_W-1:0] exm_val,
        input logic              wb_we,
        input logic [4:0]        wb_dst,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] result;
        result = rf_val;
        if (FWD_EN && (src_addr != 5'd0)) begin
            if (exm_we && (exm_dst == src_addr)) begin
                result = exm_val;
            end else if (wb_we && (wb_dst == src_addr)) begin
                result = wb_val;
            end
        end
        return result;
    endfunction

    // Returns {illegal, control}.
    function automatic logic [4:0] decode_ctrl(
        input logic [1:0] alu_op,
        input logic [5:0] funct
    );
        logic [3:0] ctrl;
        logic       illegal;
        ctrl    = CTRL_AND;
        illegal = 1'b0;
        case (alu_op)
            2'b00: ctrl = CTRL_ADD;
            2'b01: ctrl = CTRL_SUB;
            2'b11: ctrl = CTRL_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: ctrl = CTRL_ADD;
                    FUNCT_SUB: ctrl = CTRL_SUB;
                    FUNCT_AND: ctrl = CTRL_AND;
                    FUNCT_OR:  ctrl = CTRL_OR;
                    FUNCT_SLT: ctrl = CTRL_SLT;
                    FUNCT_NOR: ctrl = CTRL_NOR;
                    default: begin
                        ctrl    = CTRL_AND;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
        return {illegal, ctrl};
    endfunction

    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] alu_reg_1_q,   alu_reg_1_d;
    logic [DATA_W-1:0] alu_reg_2_q,   alu_reg_2_d;
    logic [3:0]        alu_control_q, alu_control_d;
    logic [DATA_W-1:0] store_data_q,  store_data_d;
    logic              illegal_op_q,  illegal_op_d;

    logic              capture;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic [4:0]        dec;

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        capture  = in_valid && in_ready && !flush;

        rs_fwd = fwd_operand(in_rs_addr, in_rs_val, exm_reg_write, exm_rd, exm_value,
                             wb_reg_write, wb_rd, wb_value);
        rt_fwd = fwd_operand(in_rt_addr, in_rt_val, exm_reg_write, exm_rd, exm_value,
                             wb_reg_write, wb_rd, wb_value);
        dec    = decode_ctrl(in_alu_op, in_funct);

        out_valid_d   = out_valid_q;
        alu_reg_1_d   = alu_reg_1_q;
        alu_reg_2_d   = alu_reg_2_q;
        alu_control_d = alu_control_q;
        store_data_d  = store_data_q;
        illegal_op_d  = illegal_op_q;

        // Flush kills both the held entry and anything arriving this cycle.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d   = 1'b1;
            alu_reg_1_d   = rs_fwd;
            alu_reg_2_d   = in_alu_src ? in_imm : rt_fwd;
            alu_control_d = dec[3:0];
            store_data_d  = rt_fwd;
            illegal_op_d  = dec[4];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            alu_reg_1_q   <= '0;
            alu_reg_2_q   <= '0;
            alu_control_q <= CTRL_AND;
            store_data_q  <= '0;
            illegal_op_q  <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            alu_reg_1_q   <= alu_reg_1_d;
            alu_reg_2_q   <= alu_reg_2_d;
            alu_control_q <= alu_control_d;
            store_data_q  <= store_data_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_reg_1   = alu_reg_1_q;
    assign alu_reg_2   = alu_reg_2_q;
    assign alu_control = alu_control_q;
    assign store_data  = store_data_q;
    assign illegal_op  = illegal_op_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: each issued instruction carries its hand-computed
// expected outputs, queued on capture and compared when the ALU side consumes it.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] sd;
        logic [3:0]  ctrl;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rs_addr;
    logic [4:0]  in_rt_addr;
    logic        in_alu_src;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_value;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_reg_1;
    logic [31:0] alu_reg_2;
    logic [3:0]  alu_control;
    logic [31:0] store_data;
    logic        illegal_op;

    int   n_chk;
    int   n_fail;
    exp_t cur_exp;
    exp_t sb[$];

    alu_issue_stage #(.DATA_W(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_alu_src(in_alu_src),
        .in_alu_op(in_alu_op), .in_funct(in_funct),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_value(exm_value),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_value(wb_value),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_reg_1(alu_reg_1), .alu_reg_2(alu_reg_2), .alu_control(alu_control),
        .store_data(store_data), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] rs_val, input logic [31:0] rt_val,
                             input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                             input logic src, input logic [1:0] op, input logic [5:0] funct);
        in_rs_val  = rs_val;
        in_rt_val  = rt_val;
        in_imm     = imm;
        in_rs_addr = rs;
        in_rt_addr = rt;
        in_alu_src = src;
        in_alu_op  = op;
        in_funct   = funct;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ev,
                           input logic ww, input logic [4:0] wrd, input logic [31:0] wv);
        exm_reg_write = ew;
        exm_rd        = erd;
        exm_value     = ev;
        wb_reg_write  = ww;
        wb_rd         = wrd;
        wb_value      = wv;
    endtask

    task automatic set_exp(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] sd,
                           input logic [3:0] ctrl, input logic ill);
        cur_exp.r1   = r1;
        cur_exp.r2   = r2;
        cur_exp.sd   = sd;
        cur_exp.ctrl = ctrl;
        cur_exp.ill  = ill;
    endtask

    task automatic issue_one();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Consumption is compared before a same-cycle capture is queued.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_val("reg_1", alu_reg_1, e.r1);
                    check_val("reg_2", alu_reg_2, e.r2);
                    check_val("store_data", store_data, e.sd);
                    check_val("control", alu_control, e.ctrl);
                    check_val("illegal_op", illegal_op, e.ill);
                end
            end else if (out_valid && flush && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            if (in_valid && in_ready && !flush) sb.push_back(cur_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] fn_tab [5];
        logic [3:0] ct_tab [5];
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ct_tab = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        set_instr(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_exp(32'h0, 32'h0, 32'h0, 4'h0, 1'b0);

        tick();
        tick();
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_control", alu_control, 4'b0000);
        check_val("rst_reg_1", alu_reg_1, 32'h0);
        check_val("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // NOR decode, then an unknown funct, then a legal op clears illegal_op.
        set_instr(32'h0F0F0000, 32'h000000F0, 32'h0, 5'd1, 5'd2, 1'b0, 2'b10, 6'b100111);
        set_exp(32'h0F0F0000, 32'h000000F0, 32'h000000F0, 4'b1100, 1'b0);
        issue_one();
        check_val("nor_valid", out_valid, 1'b1);
        check_val("nor_control", alu_control, 4'b1100);
        set_instr(32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 1'b0, 2'b10, 6'b000111);
        set_exp(32'h1, 32'h2, 32'h2, 4'b0000, 1'b1);
        issue_one();
        check_val("illegal_flag", illegal_op, 1'b1);
        foreach (fn_tab[i]) begin
            set_instr(32'h100 + i, 32'h200 + i, 32'h0, 5'd3, 5'd4, 1'b0, 2'b10, fn_tab[i]);
            set_exp(32'h100 + i, 32'h200 + i, 32'h200 + i, ct_tab[i], 1'b0);
            issue_one();
        end
        set_instr(32'h5, 32'h6, 32'h0, 5'd3, 5'd4, 1'b0, 2'b00, 6'b111111);
        set_exp(32'h5, 32'h6, 32'h6, 4'b0010, 1'b0);
        issue_one();
        tick();
        check_val("drain_valid", out_valid, 1'b0);
        check_val("drain_hold_reg_1", alu_reg_1, 32'h5);

        // Forwarding: EX/MEM over MEM/WB, $zero never forwarded, MEM/WB alone.
        set_instr(32'hAAAA, 32'hBBBB, 32'h0, 5'd5, 5'd5, 1'b0, 2'b00, 6'd0);
        set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        set_exp(32'h11, 32'h11, 32'h11, 4'b0010, 1'b0);
        issue_one();
        set_instr(32'h1234, 32'h5678, 32'h0, 5'd0, 5'd0, 1'b0, 2'b00, 6'd0);
        set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        set_exp(32'h1234, 32'h5678, 32'h5678, 4'b0010, 1'b0);
        issue_one();
        set_instr(32'h70, 32'h80, 32'h0, 5'd7, 5'd8, 1'b0, 2'b01, 6'd0);
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        set_exp(32'h22, 32'h80, 32'h80, 4'b0110, 1'b0);
        issue_one();

        // Immediate operand B; store_data still carries the forwarded rt.
        set_instr(32'h10, 32'h33, 32'hFFFFFFFC, 5'd1, 5'd9, 1'b1, 2'b11, 6'd0);
        set_fwd(1'b0, 5'd9, 32'h77, 1'b1, 5'd9, 32'h99);
        set_exp(32'h10, 32'hFFFFFFFC, 32'h99, 4'b0001, 1'b0);
        issue_one();
        tick();

        // Stall with a waiting instruction; held entry is not re-forwarded.
        out_ready = 1'b0;
        set_instr(32'h0, 32'h0, 32'h0, 5'd4, 5'd0, 1'b0, 2'b00, 6'd0);
        set_fwd(1'b1, 5'd4, 32'hA1, 1'b0, 5'd0, 32'h0);
        set_exp(32'hA1, 32'h0, 32'h0, 4'b0010, 1'b0);
        issue_one();
        set_instr(32'hB0, 32'hB1, 32'h0, 5'd6, 5'd0, 1'b0, 2'b01, 6'd0);
        set_fwd(1'b1, 5'd4, 32'hB2, 1'b0, 5'd0, 32'h0);
        set_exp(32'hB0, 32'hB1, 32'hB1, 4'b0110, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_val("stall_in_ready", in_ready, 1'b0);
            check_val("stall_valid", out_valid, 1'b1);
            check_val("stall_reg_1", alu_reg_1, 32'hA1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_val("b2b_valid", out_valid, 1'b1);
        check_val("b2b_reg_1", alu_reg_1, 32'hB0);
        tick();
        check_val("consumed_valid", out_valid, 1'b0);

        // Flush kills the held entry and the incoming one.
        out_ready = 1'b0;
        set_instr(32'hC0, 32'hC1, 32'h0, 5'd2, 5'd3, 1'b0, 2'b00, 6'd0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_exp(32'hC0, 32'hC1, 32'hC1, 4'b0010, 1'b0);
        issue_one();
        check_val("held_valid", out_valid, 1'b1);
        set_instr(32'hD0, 32'hD1, 32'h0, 5'd2, 5'd3, 1'b0, 2'b01, 6'd0);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        check_val("flush_valid", out_valid, 1'b0);
        check_val("flush_in_ready", in_ready, 1'b1);
        tick();
        check_val("flush_drop_incoming", out_valid, 1'b0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        // Asynchronous reset while stalled on an illegal op.
        out_ready = 1'b0;
        set_instr(32'hE0, 32'hE1, 32'h0, 5'd2, 5'd3, 1'b0, 2'b10, 6'b111000);
        set_exp(32'hE0, 32'hE1, 32'hE1, 4'b0000, 1'b1);
        issue_one();
        check_val("pre_rst_illegal", illegal_op, 1'b1);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", out_valid, 1'b0);
        check_val("async_rst_reg_1", alu_reg_1, 32'h0);
        check_val("async_rst_reg_2", alu_reg_2, 32'h0);
        check_val("async_rst_store", store_data, 32'h0);
        check_val("async_rst_illegal", illegal_op, 1'b0);
        sb.delete();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_val("post_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        tick();
        check_val("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
